enabler: RTL and testbench
==========================

ENABLER -- requirements
Module: enabler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SETUP_CYC, 2, clocks from rs update to en rise (RS setup, 72 ns at 36 ns clock); legal 1..255.
- PULSE_CYC, 13, clocks en is held high (468 ns at 36 ns clock); legal 1..255.
- HOLD_CYC, 2, clocks rs is held after en falls; legal 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, asynchronous active-low reset.
- go, input, 1, start request, level-sensitive.
- enable, input, 1, block enable; gates new starts.
- rs_in, input, 1, register-select value for the next transaction.
- rs, output, 1, registered LCD register-select line.
- en, output, 1, registered LCD E strobe.
- en_done, output, 1, one-clock completion pulse.
REQ-003 The design SHALL have one clock and one asynchronous active-low reset (rst); no other clock or reset.

Function
REQ-004 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, DONE, with an 8-bit down-counter.
REQ-005 In IDLE, on a rising edge with go=1 and enable=1, the FSM SHALL go to SETUP, latch rs<=rs_in and load the counter for SETUP_CYC.
REQ-006 SETUP SHALL last exactly SETUP_CYC clocks with en=0, then go to PULSE.
REQ-007 PULSE SHALL last exactly PULSE_CYC clocks with en=1, then go to HOLD.
REQ-008 HOLD SHALL last exactly HOLD_CYC clocks with en=0, then go to DONE.
REQ-009 DONE SHALL last one clock with en_done=1, then always go to IDLE.
REQ-010 en_done SHALL be 0 in every state except DONE.
REQ-011 rs SHALL change only at the start edge (REQ-005) and SHALL hold its value in all other states, including IDLE after completion.
REQ-012 en SHALL rise SETUP_CYC clocks after the start edge and SHALL fall PULSE_CYC clocks later.
REQ-013 en_done SHALL rise SETUP_CYC+PULSE_CYC+HOLD_CYC clocks after the start edge.
REQ-014 go and enable SHALL be ignored outside IDLE; an in-flight transaction SHALL always complete, even if enable or go deasserts.
REQ-015 rs_in SHALL be ignored outside the start edge.
REQ-016 If go=1 and enable=1 are held continuously, transactions SHALL repeat back-to-back, with period SETUP_CYC+PULSE_CYC+HOLD_CYC+2 clocks (19 with defaults), IDLE occupying exactly one clock between them.
REQ-017 enable=0 in IDLE SHALL keep the block in IDLE regardless of go.
REQ-018 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-019 While rst=0, the block SHALL be in IDLE with rs=0, en=0, en_done=0 and the counter at 0.
REQ-020 Assertion of rst SHALL take effect immediately, without waiting for clk, including mid-transaction: en SHALL drop at once and no en_done SHALL be produced for the aborted transaction.
REQ-021 After rst deasserts, the first start SHALL be evaluated at the first rising clk edge.

Verification
REQ-022 With defaults, go=1, enable=1, rs_in=1 and one start edge:
- rs=1 from the start edge;
- en=1 for exactly 13 clocks, beginning 2 clocks after start;
- en_done=1 for 1 clock, 17 clocks after start.
REQ-023 With go=1 and enable=1 held for 40 clocks: en rising edges SHALL be 19 clocks apart, and one en_done SHALL occur per en pulse.
REQ-024 enable=0 with go=1 for 30 clocks -> en=0, en_done=0, rs unchanged.
REQ-025 enable dropped 5 clocks after start -> the current pulse completes (13-clock en, en_done once) and no new start follows.
REQ-026 rs_in toggled during PULSE -> rs stays at the value latched at start; the next transaction (rs_in=0) -> rs=0 at its start edge.
REQ-027 rst driven low during PULSE between clock edges -> en=0 and rs=0 immediately, no en_done, and restart from IDLE after release.

Source files
------------

// File: rtl/enabler.sv
// -----------------------------------------------------------------------------
// enabler
//
// Generates one LCD bus strobe transaction: the register-select line (rs) is
// latched at the start edge, the E strobe (en) rises after a setup interval,
// stays high for the pulse interval, and a hold interval follows before a
// one-clock completion pulse (en_done).  Timing is counted in clk cycles by a
// single 8-bit down-counter shared by all timed states.
//
// Parameters
//   SETUP_CYC : clocks from the rs update to the en rise          (1..255)
//   PULSE_CYC : clocks en is held high                            (1..255)
//   HOLD_CYC  : clocks rs is held after en falls                  (1..255)
//
// Ports
//   clk     : in  - single clock, all state changes on its rising edge
//   rst     : in  - asynchronous active-low reset
//   go      : in  - start request, level-sensitive, sampled in IDLE only
//   enable  : in  - block enable, gates new starts (sampled in IDLE only)
//   rs_in   : in  - register-select value captured at the start edge
//   rs      : out - registered LCD register-select line
//   en      : out - registered LCD E strobe
//   en_done : out - registered one-clock completion pulse
// -----------------------------------------------------------------------------
module enabler #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 13,
   parameter int unsigned HOLD_CYC  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic enable,
   input  logic rs_in,
   output logic rs,
   output logic en,
   output logic en_done
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] PULSE = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC);
   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC);

   logic [2:0] state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       rs_reg, rs_next;
   logic       en_reg, en_next;
   logic       done_reg, done_next;
   logic       cnt_last;

   // The counter is loaded with the state length on entry; the state is left
   // on the edge where the counter reads 1, so a load of N yields N clocks.
   assign cnt_last = (cnt_reg == 8'd1);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rs_next    = rs_reg;

      case (state_reg)
         IDLE: begin
            cnt_next = 8'd0;
            if (go && enable) begin
               state_next = SETUP;
               cnt_next   = SETUP_LOAD;
               rs_next    = rs_in;
            end
         end
         SETUP: begin
            if (cnt_last) begin
               state_next = PULSE;
               cnt_next   = PULSE_LOAD;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         PULSE: begin
            if (cnt_last) begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_last) begin
               state_next = DONE;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so en and
   // en_done line up exactly with the state they belong to while still
   // coming straight from flops.
   always_comb begin
      en_next   = (state_next == PULSE);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
         rs_reg    <= 1'b0;
         en_reg    <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rs_reg    <= rs_next;
         en_reg    <= en_next;
         done_reg  <= done_next;
      end
   end

   assign rs      = rs_reg;
   assign en      = en_reg;
   assign en_done = done_reg;

endmodule

// File: tb/tb_enabler.sv
module tb_enabler;

   localparam int S = 2;
   localparam int P = 13;
   localparam int H = 2;

   logic clk = 1'b0;
   logic rst, go, enable, rs_in;
   logic rs, en, en_done;

   enabler #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .enable  (enable),
      .rs_in   (rs_in),
      .rs      (rs),
      .en      (en),
      .en_done (en_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: time since start edge, independent of any state encoding.
   bit         m_busy = 1'b0;
   int         m_t    = 0;
   bit         m_rs   = 1'b0;
   logic [2:0] sb_q[$];

   // Observation trackers driven by DUT outputs.
   int  cyc       = 0;
   int  last_rise = -1;
   int  rise_gap  = 0;
   int  width     = 0;
   int  rises     = 0;
   int  dones     = 0;
   int  done_cyc  = 0;
   logic prev_en  = 1'b0;

   task automatic model_step();
      logic [2:0] e;
      if (!rst) begin
         m_busy = 1'b0;
         m_t    = 0;
         m_rs   = 1'b0;
      end else if (!m_busy) begin
         if (go && enable) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_rs   = rs_in;
         end
      end else begin
         m_t++;
         if (m_t == S + P + H + 1) begin
            m_busy = 1'b0;
            m_t    = 0;
         end
      end
      e[2] = m_rs;
      e[1] = m_busy && (m_t >= S) && (m_t < S + P);
      e[0] = m_busy && (m_t == S + P + H);
      sb_q.push_back(e);
   endtask

   task automatic tick();
      logic [2:0] e;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      $display("cyc %0d rst=%0b go=%0b enable=%0b rs_in=%0b -> rs=%0b en=%0b en_done=%0b (exp %03b)",
               cyc, rst, go, enable, rs_in, rs, en, en_done, e);
      check("cyc_out", {29'd0, rs, en, en_done}, {29'd0, e});
      if (en && !prev_en) begin
         if (last_rise >= 0) rise_gap = cyc - last_rise;
         last_rise = cyc;
         rises++;
      end
      if (!en && prev_en) width = cyc - last_rise;
      if (en_done) begin
         dones++;
         done_cyc = cyc;
      end
      prev_en = en;
   endtask

   int start, d0, r0;

   initial begin
      rst = 1'b0; go = 1'b0; enable = 1'b0; rs_in = 1'b0;
      #1;
      check("rst_out", {29'd0, rs, en, en_done}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;

      // Single transaction, rs_in=1.
      go = 1'b1; enable = 1'b1; rs_in = 1'b1;
      tick(); start = cyc;
      go = 1'b0;
      repeat (20) tick();
      check("single_rise", last_rise - start, S);
      check("single_width", width, P);
      check("single_done", done_cyc - start, S + P + H);
      check("single_rs", rs, 1'b1);

      // Back-to-back for 40 clocks.
      d0 = dones; r0 = rises;
      go = 1'b1; enable = 1'b1;
      repeat (40) tick();
      go = 1'b0;
      repeat (20) tick();
      check("b2b_gap", rise_gap, S + P + H + 2);
      check("b2b_rises", rises - r0, 3);
      check("b2b_dones", dones - d0, rises - r0);

      // enable=0 blocks starts.
      d0 = dones; r0 = rises;
      go = 1'b1; enable = 1'b0; rs_in = 1'b0;
      repeat (30) tick();
      check("dis_rises", rises - r0, 0);
      check("dis_dones", dones - d0, 0);
      check("dis_rs", rs, 1'b1);

      // enable dropped mid-transaction.
      d0 = dones; r0 = rises;
      enable = 1'b1; rs_in = 1'b0;
      tick();
      repeat (5) tick();
      enable = 1'b0;
      repeat (30) tick();
      go = 1'b0;
      check("drop_width", width, P);
      check("drop_rises", rises - r0, 1);
      check("drop_dones", dones - d0, 1);

      // rs_in toggled during the pulse.
      enable = 1'b1; go = 1'b1; rs_in = 1'b1;
      tick();
      go = 1'b0;
      repeat (4) tick();
      rs_in = 1'b0; tick();
      rs_in = 1'b1; tick();
      check("tog_rs", rs, 1'b1);
      rs_in = 1'b0;
      repeat (15) tick();
      check("tog_rs_after", rs, 1'b1);
      go = 1'b1; rs_in = 1'b0;
      tick();
      check("next_rs", rs, 1'b0);
      go = 1'b0;
      repeat (20) tick();

      // Asynchronous reset during the pulse.
      go = 1'b1; rs_in = 1'b1;
      tick();
      go = 1'b0;
      repeat (6) tick();
      check("pre_rst_en", en, 1'b1);
      d0 = dones;
      #3 rst = 1'b0;
      #1;
      check("arst_en", en, 1'b0);
      check("arst_rs", rs, 1'b0);
      check("arst_done", en_done, 1'b0);
      repeat (3) tick();
      check("arst_nodone", dones - d0, 0);
      rst = 1'b1; go = 1'b1; enable = 1'b1; rs_in = 1'b1;
      tick(); start = cyc;
      go = 1'b0;
      repeat (20) tick();
      check("restart_rise", last_rise - start, S);
      check("restart_dones", dones - d0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
